bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq_pkg.sv | 28 ++
 rtl/bcd_digit_adjust.sv | 10 +
 rtl/bin_to_bcd_seq.sv | 105 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Double-dabble sizing plus the saturation pattern for the display limit.
package bin_to_bcd_seq_pkg;

  localparam int BIN_W       = 16;
  localparam int BCD_W       = 20;
  localparam int ITER        = 16;
  localparam int MAX_DISPLAY = 9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [15:0] dec_to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  localparam logic [15:0] SAT_BCD = dec_to_bcd(MAX_DISPLAY);
  localparam logic [BCD_W-1:0] MAX_ACC = {4'd0, SAT_BCD};

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit.
// Adds 3 when the digit is 5 or more so the next shift carries correctly.
module bcd_digit_adjust (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter, one bit per clock.
// Valid/ready on both sides; result held in DONE until accepted.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic             clock_100Mhz,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [BIN_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      bcd,
  output logic             overflow
);

  state_t r_state;
  state_t w_next_state;

  logic [BIN_W-1:0] r_shift;
  logic [BCD_W-1:0] r_acc;
  logic [4:0]       r_cnt;
  logic [15:0]      r_bcd;
  logic             r_ovf;
  logic             r_out_valid;

  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_acc_next;
  logic [BIN_W-1:0] w_shift_next;
  logic             w_last;
  logic             w_ovf;
  logic [15:0]      w_bcd;

  for (genvar g = 0; g < BCD_W / 4; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  assign w_acc_next   = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
  assign w_shift_next = {r_shift[BIN_W-2:0], 1'b0};
  assign w_last       = (r_cnt == 5'(ITER - 1));
  assign w_ovf        = (w_acc_next > MAX_ACC);
  assign w_bcd        = (w_ovf && SATURATE) ? SAT_BCD
                                            : w_acc_next[15:0];

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next_state = SHIFT;
      SHIFT:   if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      r_shift     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift <= in_data;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_acc   <= w_acc_next;
          r_shift <= w_shift_next;
          r_cnt   <= r_cnt + 5'd1;
          if (w_last) begin
            r_bcd       <= w_bcd;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign bcd       = r_bcd;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq, both SATURATE settings side by side.
// Expected BCD patterns are hand-computed per vector.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        rdy_s, ov_s, ovf_s;
  logic [15:0] bcd_s;
  logic        rdy_m, ov_m, ovf_m;
  logic [15:0] bcd_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.SATURATE(1'b1)) u_sat (
    .clock_100Mhz (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (rdy_s),
    .out_valid    (ov_s),
    .out_ready    (out_ready),
    .bcd          (bcd_s),
    .overflow     (ovf_s)
  );

  bin_to_bcd_seq #(.SATURATE(1'b0)) u_mod (
    .clock_100Mhz (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (rdy_m),
    .out_valid    (ov_m),
    .out_ready    (out_ready),
    .bcd          (bcd_m),
    .overflow     (ovf_m)
  );

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, act, exp);
    end
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ov_s && lat < 40);
    if (!ov_s) check("timeout", 32'(ov_s), 32'd1);
  endtask

  task automatic convert(input logic [15:0] d,
                         input logic [15:0] e_sat,
                         input logic [15:0] e_mod,
                         input logic        e_ovf);
    int lat;
    @(negedge clk);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check("in_ready", 32'(rdy_s), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(lat);
    check("latency", 32'(lat), 32'd16);
    check("ov_mod", 32'(ov_m), 32'd1);
    check("bcd_sat", 32'(bcd_s), 32'(e_sat));
    check("ovf_sat", 32'(ovf_s), 32'(e_ovf));
    check("bcd_mod", 32'(bcd_m), 32'(e_mod));
    check("ovf_mod", 32'(ovf_m), 32'(e_ovf));
    @(posedge clk);
    #1;
    check("ov_clear", 32'(ov_s), 32'd0);
    check("rdy_back", 32'(rdy_s), 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    check("rst_rdy", 32'(rdy_s), 32'd1);
    check("rst_ov", 32'(ov_s), 32'd0);
    check("rst_bcd", 32'(bcd_s), 32'd0);
    check("rst_ovf", 32'(ovf_s), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    convert(16'd1234,  16'h1234, 16'h1234, 1'b0);
    convert(16'd0,     16'h0000, 16'h0000, 1'b0);
    convert(16'd9999,  16'h9999, 16'h9999, 1'b0);
    convert(16'd10000, 16'h9999, 16'h0000, 1'b1);
    convert(16'd65535, 16'h9999, 16'h5535, 1'b1);
    convert(16'd5,     16'h0005, 16'h0005, 1'b0);
    convert(16'd8086,  16'h8086, 16'h8086, 1'b0);

    // backpressure with a new word offered throughout
    @(negedge clk);
    out_ready = 1'b0;
    in_data   = 16'd5678;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(lat);
    check("bp_lat", 32'(lat), 32'd16);
    check("bp_bcd0", 32'(bcd_s), 32'h5678);
    in_valid = 1'b1;
    in_data  = 16'd777;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_bcd", 32'(bcd_s), 32'h5678);
      check("bp_ov", 32'(ov_s), 32'd1);
      check("bp_rdy", 32'(rdy_s), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_ov", 32'(ov_s), 32'd0);
    check("hs_rdy", 32'(rdy_s), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("acc2_rdy", 32'(rdy_s), 32'd0);
    wait_result(lat);
    check("bp2_lat", 32'(lat), 32'd16);
    check("bp2_bcd", 32'(bcd_s), 32'h0777);
    @(posedge clk);
    #1;

    // reset during the 8th shift cycle
    @(negedge clk);
    in_data  = 16'd4321;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_rdy", 32'(rdy_s), 32'd0);
    reset = 1'b1;
    #1;
    check("ar_rdy", 32'(rdy_s), 32'd1);
    check("ar_ov", 32'(ov_s), 32'd0);
    check("ar_bcd", 32'(bcd_s), 32'd0);
    check("ar_ovf", 32'(ovf_s), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 seen = seen | ov_s | ov_m;
    end
    check("no_pulse", 32'(seen), 32'd0);
    convert(16'd42, 16'h0042, 16'h0042, 1'b0);

    // input changes during shift are ignored
    @(negedge clk);
    in_data  = 16'd1111;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 16'd2222;
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!ov_s && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check("chg_ov", 32'(ov_s), 32'd1);
    check("chg_bcd", 32'(bcd_s), 32'h1111);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
